neosd_dma: RTL and testbench
============================

NEOSD_DMA -- requirements
Module: neosd_dma

Interface
REQ-001 SHALL have parameter NEOSD_BASE, default 32'h9000_0000, byte base address of the SD controller register file.
REQ-002 SHALL have parameter POLL_LIMIT, default 16'hFFFF, maximum status polls per word before timeout.
REQ-003 SHALL use one clock; reset is asynchronous and active-high: clk_i  in  1  rising-edge clock.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 start_i  in  1  one-cycle pulse; accepted only in IDLE.
REQ-006 dir_i  in  1  sampled at start: 0 = card->memory, 1 = memory->card.
REQ-007 mem_adr_i  in  32  word-aligned memory start address, sampled at start.
REQ-008 nwords_i  in  8  words to move, sampled at start; 0 means 256.
REQ-009 abort_i  in  1  level; terminates the transfer at the next bus-idle point.
REQ-010 busy_o  out  1; done_o  out  1 (one-cycle pulse); err_o  out  1 (sticky until next accepted start).
REQ-011 wb_adr_o 32, wb_dat_o 32, wb_we_o 1, wb_sel_o 4, wb_stb_o 1, wb_cyc_o 1: outputs, classic Wishbone master.
REQ-012 wb_dat_i 32, wb_ack_i 1, wb_err_i 1: inputs, classic Wishbone master.

Function
REQ-013 SHALL have states IDLE, POLL, RD_DATA, WR_MEM, RD_MEM, WR_DATA, DONE, ERR.
REQ-014 Bus: at most one cycle outstanding; stb/cyc asserted together and held with stable adr/dat/we until ack or err; wb_sel_o = 4'hF always.
REQ-015 Bus cycle ends on the cycle ack or err is sampled high; stb/cyc deassert on the next edge; there are no back-to-back cycles.
REQ-016 IDLE + start_i: latch dir, address, count; clear err_o; set busy_o next cycle; go to POLL (dir=0) or RD_MEM (dir=1).
REQ-017 POLL: read NEOSD_BASE+0x08; if bit 3 (DAT_DATA) = 1, go to RD_DATA (dir=0) or WR_DATA (dir=1); else increment the poll counter and re-poll.
REQ-018 Poll counter resets to 0 per word; when the counter reaches POLL_LIMIT with bit 3 still 0, go to ERR.
REQ-019 RD_DATA: read NEOSD_BASE+0x1C and hold the word in an internal buffer, then go to WR_MEM.
REQ-020 WR_MEM: write the buffer to the current address; on ack add 4 to the address (32-bit wrap) and decrement the count.
REQ-021 RD_MEM: read the current address into the buffer, then go to POLL.
REQ-022 WR_DATA: write the buffer to NEOSD_BASE+0x1C; on ack add 4 to the address and decrement the count.
REQ-023 After the count decrement, if the count reaches 0, go to DONE; else go to POLL (dir=0) or RD_MEM (dir=1).
REQ-024 DONE: pulse done_o for one cycle, clear busy_o, and return to IDLE.
REQ-025 wb_err_i during any cycle SHALL end that cycle and go to ERR.
REQ-026 ERR: set err_o, pulse done_o for one cycle, clear busy_o, and return to IDLE.
REQ-027 abort_i sampled with no bus cycle open, or on the ack of the open cycle, goes to ERR; the open cycle is never dropped early.
REQ-028 A word whose memory write was not acked SHALL NOT be counted.
REQ-029 start_i while busy SHALL be ignored.
REQ-030 A 256-word transfer uses an 8-bit counter plus a nonzero flag; the counter wraps from 0 to 255 without early termination.

Reset
REQ-031 On rst_i: state = IDLE; busy_o, done_o, err_o, wb_stb_o, wb_cyc_o, wb_we_o = 0; wb_adr_o, wb_dat_o = 0; counters cleared.
REQ-032 rst_i asserted mid-transfer SHALL drop stb/cyc immediately and asynchronously; no partial state survives.
REQ-033 The first start is accepted on the first rising clk_i edge after rst_i deasserts.

Verification
REQ-034 dir=0, nwords=4, mem_adr=0x100, DAT_DATA set on every poll -> 4 reads of 0x9000_001C, writes to 0x100/104/108/10C with matching data, then one done_o pulse and err_o=0.
REQ-035 dir=1, nwords=2, DAT_DATA=0 for the first 3 polls -> per word: memory read, 4 polls, then a write to 0x9000_001C with the memory data; done_o after 2 words.
REQ-036 POLL_LIMIT=8 and DAT_DATA never set -> ERR after the 8th poll, err_o=1 and done_o pulse, with no 0x1C access.
REQ-037 wb_err_i on the 2nd memory write -> err_o=1, and only 1 word counted.
REQ-038 abort_i raised while waiting for ack -> the cycle completes, no further bus cycle follows, and err_o=1.
REQ-039 nwords=0, mem_adr=0xFFFF_FC00 -> 256 words transferred and the address wraps to 0x0000_0000 on the last increment.

Source files
------------

// File: rtl/neosd_dma.sv
// -----------------------------------------------------------------------------
// neosd_dma
// Moves 32-bit words between system memory and the NEOSD SD-card controller
// data register over a classic Wishbone master port. Each word is gated by
// polling the controller status register until DAT_DATA (bit 3) is set.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 one-cycle start pulse (only honoured while idle)
//   dir_i                   0 = card -> memory, 1 = memory -> card
//   mem_adr_i               word-aligned memory start address
//   nwords_i                number of words to move (0 means 256)
//   abort_i                 level request to stop at the next bus-idle point
//   busy_o                  transfer in progress
//   done_o                  one-cycle pulse at the end of every transfer
//   err_o                   sticky error flag, cleared by the next start
//   wb_*                    classic Wishbone master (one cycle outstanding)
// -----------------------------------------------------------------------------
module neosd_dma #(
    parameter logic [31:0] NEOSD_BASE = 32'h9000_0000,
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        dir_i,
    input  logic [31:0] mem_adr_i,
    input  logic [7:0]  nwords_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [31:0] STATUS_ADR = NEOSD_BASE + 32'h0000_0008;
    localparam logic [31:0] DATA_ADR   = NEOSD_BASE + 32'h0000_001C;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        RD_DATA,
        WR_MEM,
        RD_MEM,
        WR_DATA,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic        cyc_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        we_q;
    logic        dir_q;
    logic [31:0] mem_adr_q;
    logic [7:0]  count_q;
    logic [15:0] poll_q;
    logic [31:0] buf_q;
    logic        err_q;

    logic        load_start;
    logic        bus_open;
    logic        bus_close;
    logic        load_buf;
    logic        advance;
    logic        poll_inc;
    logic        poll_clr;
    logic [31:0] open_adr;
    logic [31:0] open_dat;
    logic        open_we;

    // State register. The reset is asynchronous so an in-flight transfer is
    // abandoned the instant rst_i rises.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes. Every bus state works the same way:
    // with no cycle open it either honours abort or opens its cycle; with a
    // cycle open it waits for ack/err, which closes the cycle on the next edge.
    // Because the next state only opens its cycle one edge after the close,
    // back-to-back cycles never happen. The word counter is loaded with
    // nwords_i directly; finishing on count==1 before the decrement lets a
    // loaded 0 wrap through 255 and so move 256 words.
    always_comb begin
        state_next = state;
        load_start = 1'b0;
        bus_open   = 1'b0;
        bus_close  = 1'b0;
        load_buf   = 1'b0;
        advance    = 1'b0;
        poll_inc   = 1'b0;
        poll_clr   = 1'b0;
        open_adr   = STATUS_ADR;
        open_dat   = 32'h0000_0000;
        open_we    = 1'b0;

        case (state)
            RD_DATA: open_adr = DATA_ADR;
            WR_MEM: begin
                open_adr = mem_adr_q;
                open_dat = buf_q;
                open_we  = 1'b1;
            end
            RD_MEM:  open_adr = mem_adr_q;
            WR_DATA: begin
                open_adr = DATA_ADR;
                open_dat = buf_q;
                open_we  = 1'b1;
            end
            default: ;
        endcase

        case (state)
            IDLE: begin
                if (start_i) begin
                    load_start = 1'b1;
                    state_next = dir_i ? RD_MEM : POLL;
                end
            end
            POLL, RD_DATA, WR_MEM, RD_MEM, WR_DATA: begin
                if (!cyc_q) begin
                    if (abort_i) begin
                        state_next = ERR;
                    end else begin
                        bus_open = 1'b1;
                    end
                end else if (wb_err_i) begin
                    bus_close  = 1'b1;
                    state_next = ERR;
                end else if (wb_ack_i) begin
                    bus_close = 1'b1;
                    case (state)
                        POLL: begin
                            if (wb_dat_i[3]) begin
                                poll_clr   = 1'b1;
                                state_next = dir_q ? WR_DATA : RD_DATA;
                            end else if (poll_q == POLL_LIMIT - 16'd1) begin
                                state_next = ERR;
                            end else begin
                                poll_inc = 1'b1;
                            end
                        end
                        RD_DATA: begin
                            load_buf   = 1'b1;
                            state_next = WR_MEM;
                        end
                        RD_MEM: begin
                            load_buf   = 1'b1;
                            state_next = POLL;
                        end
                        default: begin
                            // Acked write (WR_MEM or WR_DATA): the word counts.
                            advance = 1'b1;
                            if (count_q == 8'd1) begin
                                state_next = DONE;
                            end else begin
                                state_next = dir_q ? RD_MEM : POLL;
                            end
                        end
                    endcase
                    if (abort_i) begin
                        state_next = ERR;
                    end
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: transfer parameters, the Wishbone output registers, the word
    // buffer and the per-word poll counter. Bus outputs only change when a
    // cycle opens or closes, so adr/dat/we stay stable while stb is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q     <= 1'b0;
            adr_q     <= 32'h0000_0000;
            dat_q     <= 32'h0000_0000;
            we_q      <= 1'b0;
            dir_q     <= 1'b0;
            mem_adr_q <= 32'h0000_0000;
            count_q   <= 8'd0;
            poll_q    <= 16'd0;
            buf_q     <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            if (load_start) begin
                dir_q     <= dir_i;
                mem_adr_q <= mem_adr_i;
                count_q   <= nwords_i;
                poll_q    <= 16'd0;
                err_q     <= 1'b0;
            end
            if (bus_open) begin
                cyc_q <= 1'b1;
                adr_q <= open_adr;
                dat_q <= open_dat;
                we_q  <= open_we;
            end else if (bus_close) begin
                cyc_q <= 1'b0;
                we_q  <= 1'b0;
            end
            if (load_buf) begin
                buf_q <= wb_dat_i;
            end
            if (advance) begin
                mem_adr_q <= mem_adr_q + 32'd4;
                count_q   <= count_q - 8'd1;
            end
            if (poll_clr) begin
                poll_q <= 16'd0;
            end else if (poll_inc) begin
                poll_q <= poll_q + 16'd1;
            end
            if (state_next == ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    // Status outputs follow the state directly: DONE and ERR each last one
    // cycle, which gives the done pulse with busy already low.
    assign busy_o   = (state != IDLE) && (state != DONE) && (state != ERR);
    assign done_o   = (state == DONE) || (state == ERR);
    assign err_o    = err_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = 4'hF;
    assign wb_stb_o = cyc_q;
    assign wb_cyc_o = cyc_q;

endmodule

// File: tb/tb_neosd_dma.sv
// -----------------------------------------------------------------------------
// tb_neosd_dma
// Self-checking bench for neosd_dma. A Wishbone slave model answers status,
// card-data and memory accesses and logs every completed bus cycle. For each
// transfer a reference model expands the per-word plan (not-ready poll counts,
// card words, memory contents) into the expected sequence of bus cycles.
// -----------------------------------------------------------------------------
module tb_neosd_dma;

    localparam logic [31:0] BASE        = 32'h9000_0000;
    localparam int          LIMIT       = 8;
    localparam logic [31:0] STATUS_JUNK = 32'h5A5A_A5A7;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic        err;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] memAdr = 32'h0;
    logic [7:0]  nwords = 8'h0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] adrO;
    logic [31:0] datO;
    logic        weO;
    logic [3:0]  selO;
    logic        stbO;
    logic        cycO;
    logic [31:0] rdat = 32'h0;
    logic        ack = 1'b0;
    logic        berr = 1'b0;

    int   total = 0;
    int   bad = 0;
    txn_t logQ[$];
    txn_t expQ[$];
    logic statusQ[$];
    logic [31:0] cardQ[$];
    int   txnIdx = 0;
    int   errTxn = -1;
    int   waitCnt = 0;
    int   curLat = 0;
    int   latForce = 0;
    logic expErr = 1'b0;
    txn_t slvT;
    logic slvRdy;

    neosd_dma #(
        .NEOSD_BASE(BASE),
        .POLL_LIMIT(16'd8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .dir_i    (dir),
        .mem_adr_i(memAdr),
        .nwords_i (nwords),
        .abort_i  (abort),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .wb_adr_o (adrO),
        .wb_dat_o (datO),
        .wb_we_o  (weO),
        .wb_sel_o (selO),
        .wb_stb_o (stbO),
        .wb_cyc_o (cycO),
        .wb_dat_i (rdat),
        .wb_ack_i (ack),
        .wb_err_i (berr)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address, so the model can
    // predict any memory read without tracking state.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // Wishbone slave model, acting on the falling edge so the DUT sees ack/err
    // for exactly one rising edge. Latency is random (or forced), the status
    // register answers from the per-word ready plan, and one chosen cycle can
    // be answered with err. Every completed cycle is logged.
    always @(negedge clk) begin
        if (rst) begin
            ack     = 1'b0;
            berr    = 1'b0;
            waitCnt = 0;
        end else if (ack || berr) begin
            ack  = 1'b0;
            berr = 1'b0;
        end else if (cycO && stbO) begin
            if (waitCnt < curLat) begin
                waitCnt++;
            end else begin
                waitCnt  = 0;
                curLat   = (latForce > 0) ? latForce : int'($urandom_range(0, 3));
                slvT.adr = adrO;
                slvT.we  = weO;
                slvT.err = 1'b0;
                rdat     = 32'h0;
                if (txnIdx == errTxn) begin
                    berr     = 1'b1;
                    slvT.err = 1'b1;
                    slvT.dat = weO ? datO : 32'h0;
                end else begin
                    ack = 1'b1;
                    if (weO) begin
                        slvT.dat = datO;
                    end else begin
                        if (adrO == BASE + 32'h08) begin
                            slvRdy = (statusQ.size() > 0) ? statusQ.pop_front() : 1'b0;
                            rdat   = STATUS_JUNK | {28'h0, slvRdy, 3'b000};
                        end else if (adrO == BASE + 32'h1C) begin
                            rdat = (cardQ.size() > 0) ? cardQ.pop_front() : 32'hDEAD_BEEF;
                        end else begin
                            rdat = memWord(adrO);
                        end
                        slvT.dat = rdat;
                    end
                end
                logQ.push_back(slvT);
                txnIdx++;
            end
        end
    end

    // One comparison: counts it, and on mismatch counts the failure and reports.
    task automatic checkOutput(input string tag, input logic [65:0] observed,
                               input logic [65:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pulses start with the given parameters (called just after a falling
    // edge), then scrambles the parameter inputs to show they are only
    // sampled at start, and checks busy rose.
    task automatic applyStimulus(input logic d, input logic [7:0] n, input logic [31:0] a);
        start  = 1'b1;
        dir    = d;
        nwords = n;
        memAdr = a;
        @(negedge clk);
        start  = 1'b0;
        dir    = ~d;
        nwords = 8'($urandom);
        memAdr = $urandom;
        checkOutput("busy_after_start", 66'(busy), 66'(1'b1));
    endtask

    // Bounded wait for the done pulse; an expired bound shows up as a failed
    // done_seen comparison.
    task automatic waitDone(input int bound);
        int i = 0;
        while (!done && i < bound) begin
            @(negedge clk);
            i++;
        end
        checkOutput("done_seen", 66'(done), 66'(1'b1));
    endtask

    // Checks the end-of-transfer flags and compares the logged bus cycles
    // against the expected list.
    task automatic checkEnd(input string name);
        checkOutput({name, "_err"}, 66'(err), 66'(expErr));
        checkOutput({name, "_busy_at_done"}, 66'(busy), 66'(1'b0));
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, 66'(done), 66'(1'b0));
        checkOutput({name, "_err_sticky"}, 66'(err), 66'(expErr));
        repeat (3) @(negedge clk);
        checkOutput({name, "_txn_count"}, 66'(logQ.size()), 66'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < logQ.size()) begin
                checkOutput($sformatf("%s_txn%0d", name, i), logQ[i], expQ[i]);
            end
        end
    endtask

    // Plans one transfer (per-word not-ready poll counts and card words),
    // derives the expected bus cycles from the transfer rules, runs it and
    // checks it. errAt >= 0 makes the slave answer that cycle with err; spurious
    // fires an extra start while busy that must be ignored.
    task automatic runTransfer(input string name, input logic d, input logic [7:0] n,
                               input logic [31:0] a, input int kMin, input int kMax,
                               input int errAt, input bit spurious);
        int          words;
        int          kq[$];
        logic [31:0] cw[$];
        logic [31:0] adr;
        int          k;
        int          polls;
        logic [31:0] c;
        txn_t        t;
        words = (n == 8'd0) ? 256 : int'(n);
        statusQ.delete();
        cardQ.delete();
        logQ.delete();
        expQ.delete();
        txnIdx = 0;
        errTxn = errAt;
        for (int w = 0; w < words; w++) begin
            k = int'($urandom_range(kMin, kMax));
            kq.push_back(k);
            repeat (k) statusQ.push_back(1'b0);
            statusQ.push_back(1'b1);
            c = $urandom;
            cw.push_back(c);
            cardQ.push_back(c);
        end

        adr    = a;
        expErr = 1'b0;
        for (int w = 0; w < words; w++) begin
            if (d) begin
                t = '{adr: adr, we: 1'b0, dat: memWord(adr), err: 1'b0};
                expQ.push_back(t);
            end
            polls = (kq[w] < LIMIT) ? kq[w] : LIMIT;
            for (int p = 0; p < polls; p++) begin
                t = '{adr: BASE + 32'h08, we: 1'b0, dat: STATUS_JUNK, err: 1'b0};
                expQ.push_back(t);
            end
            if (kq[w] >= LIMIT) begin
                expErr = 1'b1;
                break;
            end
            t = '{adr: BASE + 32'h08, we: 1'b0, dat: STATUS_JUNK | 32'h8, err: 1'b0};
            expQ.push_back(t);
            if (d) begin
                t = '{adr: BASE + 32'h1C, we: 1'b1, dat: memWord(adr), err: 1'b0};
                expQ.push_back(t);
            end else begin
                t = '{adr: BASE + 32'h1C, we: 1'b0, dat: cw[w], err: 1'b0};
                expQ.push_back(t);
                t = '{adr: adr, we: 1'b1, dat: cw[w], err: 1'b0};
                expQ.push_back(t);
            end
            adr = adr + 32'd4;
        end
        if (errAt >= 0 && errAt < expQ.size()) begin
            while (expQ.size() > errAt + 1) void'(expQ.pop_back());
            t     = expQ.pop_back();
            t.err = 1'b1;
            if (!t.we) t.dat = 32'h0;
            expQ.push_back(t);
            expErr = 1'b1;
        end

        applyStimulus(d, n, a);
        if (spurious) begin
            repeat (2) @(negedge clk);
            start  = 1'b1;
            dir    = ~d;
            nwords = 8'd1;
            memAdr = 32'hDEAD_0000;
            @(negedge clk);
            start  = 1'b0;
        end
        waitDone(20000);
        checkEnd(name);
    endtask

    // Safety net: a hang anywhere still ends the run with a reported failure.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of scenarios, with randomized data and latencies.
    initial begin
        logic        rd;
        logic [7:0]  rn;
        logic [31:0] ra;
        txn_t        t;
        int          i;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 66'(busy), 66'(1'b0));
        checkOutput("rst_done", 66'(done), 66'(1'b0));
        checkOutput("rst_err", 66'(err), 66'(1'b0));
        checkOutput("rst_cyc", 66'(cycO), 66'(1'b0));
        checkOutput("rst_stb", 66'(stbO), 66'(1'b0));
        checkOutput("rst_we", 66'(weO), 66'(1'b0));
        checkOutput("rst_adr", 66'(adrO), 66'(32'h0));
        checkOutput("rst_dat", 66'(datO), 66'(32'h0));
        checkOutput("rst_sel", 66'(selO), 66'(4'hF));

        // Release reset and start on the very next rising edge.
        rst = 1'b0;
        runTransfer("c2m4", 1'b0, 8'd4, 32'h0000_0100, 0, 0, -1, 1'b0);
        runTransfer("m2c2", 1'b1, 8'd2, 32'h0000_2000, 3, 3, -1, 1'b0);
        runTransfer("below_limit", 1'b0, 8'd3, 32'h0000_0400, LIMIT - 1, LIMIT - 1, -1, 1'b0);
        runTransfer("timeout", 1'b0, 8'd2, 32'h0000_0500, 20, 20, -1, 1'b0);
        runTransfer("err_memwr", 1'b0, 8'd4, 32'h0000_0600, 0, 0, 5, 1'b0);
        runTransfer("err_cardwr", 1'b1, 8'd3, 32'h0000_0700, 0, 0, 2, 1'b0);

        for (int r = 0; r < 5; r++) begin
            rd = 1'($urandom_range(0, 1));
            rn = 8'($urandom_range(1, 6));
            ra = $urandom;
            ra[1:0] = 2'b00;
            runTransfer($sformatf("rand%0d", r), rd, rn, ra, 0, LIMIT - 1, -1, (r == 2));
        end

        // Abort while a cycle waits for ack: the cycle completes, nothing follows.
        statusQ.delete();
        statusQ.push_back(1'b1);
        logQ.delete();
        expQ.delete();
        txnIdx   = 0;
        errTxn   = -1;
        latForce = 6;
        t = '{adr: BASE + 32'h08, we: 1'b0, dat: STATUS_JUNK | 32'h8, err: 1'b0};
        expQ.push_back(t);
        expErr = 1'b1;
        applyStimulus(1'b0, 8'd4, 32'h0000_0800);
        i = 0;
        while (!cycO && i < 20) begin
            @(negedge clk);
            i++;
        end
        checkOutput("abort_cyc_open", 66'(cycO), 66'(1'b1));
        checkOutput("abort_sel", 66'(selO), 66'(4'hF));
        abort = 1'b1;
        waitDone(50);
        checkEnd("abort");
        checkOutput("abort_bus_idle", 66'(cycO), 66'(1'b0));
        abort    = 1'b0;
        latForce = 0;

        // Reset in the middle of a transfer drops the bus at once.
        statusQ.delete();
        statusQ.push_back(1'b1);
        latForce = 5;
        applyStimulus(1'b1, 8'd3, 32'h0000_0900);
        i = 0;
        while (!cycO && i < 20) begin
            @(negedge clk);
            i++;
        end
        checkOutput("midrst_cyc_open", 66'(cycO), 66'(1'b1));
        rst = 1'b1;
        #1;
        checkOutput("midrst_cyc", 66'(cycO), 66'(1'b0));
        checkOutput("midrst_stb", 66'(stbO), 66'(1'b0));
        checkOutput("midrst_busy", 66'(busy), 66'(1'b0));
        checkOutput("midrst_adr", 66'(adrO), 66'(32'h0));
        latForce = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        runTransfer("after_rst", 1'b1, 8'd2, 32'h0000_0A00, 0, 2, -1, 1'b0);

        // 256 words ending at the top of the address space.
        runTransfer("w256", 1'b0, 8'd0, 32'hFFFF_FC00, 0, 1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
